ir_stream_loader: RTL and testbench



---
 rtl/ir_loader_pkg.sv | 23 ++
 rtl/ir_bank_regs.sv | 50 +++++
 rtl/ir_stream_loader.sv | 147 ++++++++++++++
 tb/tb_ir_stream_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ir_loader_pkg.sv
// rtl/ir_loader_pkg.sv - shared state encoding and sizing helpers for the IR stream loader.
package ir_loader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        CHECK     = 2'd2,
        WAIT_SWAP = 2'd3
    } state_t;

    // Width of the tap counter: indexes 0..window_size-1 with one bit of headroom.
    function automatic int ir_count_w(input int window_size);
        return $clog2(window_size) + 1;
    endfunction

    // Tap-0 word of the identity impulse (1.0 in the fixed-point format).
    function automatic logic [63:0] ir_identity(input int fxp_size, input int frac_size);
        logic [63:0] mask;
        mask = (fxp_size >= 64) ? {64{1'b1}} : ((64'd1 << fxp_size) - 64'd1);
        return (64'd1 << frac_size) & mask;
    endfunction

endpackage

// File: rtl/ir_bank_regs.sv
// rtl/ir_bank_regs.sv - shadow and active coefficient banks; active resets to the identity impulse.
module ir_bank_regs
    import ir_loader_pkg::*;
#(
    parameter int fxp_size    = 16,
    parameter int frac_size   = 12,
    parameter int window_size = 256,
    parameter int idx_w       = $clog2(window_size)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wr_en_i,
    input  logic [idx_w-1:0]                       wr_idx_i,
    input  logic [fxp_size-1:0]                    wr_data_i,
    input  logic                                   swap_i,
    output logic [window_size-1:0][fxp_size-1:0]   ir_o,
    output logic                                   updated_o
);

    localparam logic [fxp_size-1:0] IDENT = fxp_size'(ir_identity(fxp_size, frac_size));

    logic [fxp_size-1:0]                 shadow_q [window_size];
    logic [window_size-1:0][fxp_size-1:0] active_q;
    logic                                updated_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < window_size; i++) begin
                shadow_q[i] <= '0;
            end
            active_q    <= '0;
            active_q[0] <= IDENT;
            updated_q   <= 1'b0;
        end else begin
            if (wr_en_i) begin
                shadow_q[wr_idx_i] <= wr_data_i;
            end
            if (swap_i) begin
                for (int i = 0; i < window_size; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            updated_q <= swap_i;
        end
    end

    assign ir_o      = active_q;
    assign updated_o = updated_q;

endmodule

// File: rtl/ir_stream_loader.sv
// rtl/ir_stream_loader.sv - serial IR coefficient loader with boundary-safe bank swap.
// Optional trailing checksum beat enabled by IR_LOADER_CHECKSUM_EN.
module ir_stream_loader
    import ir_loader_pkg::*;
#(
    parameter int fxp_size    = 16,
    parameter int frac_size   = 12,
    parameter int window_size = 256
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [fxp_size-1:0]                    i_coef,
    input  logic                                   i_coef_valid,
    input  logic                                   i_coef_sof,
    output logic                                   o_coef_ready,
    input  logic                                   i_swap_ok,
    output logic [window_size-1:0][fxp_size-1:0]   o_ir,
    output logic                                   o_ir_updated,
    output logic                                   o_busy,
    output logic                                   o_err
);

    localparam int               CNT_W = ir_count_w(window_size);
    localparam int               IDX_W = CNT_W - 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(window_size - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic               beat;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic               swap;
`ifdef IR_LOADER_CHECKSUM_EN
    logic [fxp_size-1:0] sum_q, sum_d;
`endif

    assign o_coef_ready = (state_q != WAIT_SWAP);
    assign o_busy       = (state_q != IDLE);
    assign o_err        = err_q;
    assign beat         = i_coef_valid && o_coef_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = count_q[IDX_W-1:0];
        swap    = 1'b0;
`ifdef IR_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE: begin
                if (beat && i_coef_sof) begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    count_d = CNT_W'(1);
                    state_d = LOAD;
`ifdef IR_LOADER_CHECKSUM_EN
                    sum_d   = i_coef;
`endif
                end
            end
            LOAD, CHECK: begin
                if (beat) begin
                    if (i_coef_sof) begin
                        // A new frame header mid-frame restarts the load and flags the truncation.
                        err_d   = 1'b1;
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        count_d = CNT_W'(1);
                        state_d = LOAD;
`ifdef IR_LOADER_CHECKSUM_EN
                        sum_d   = i_coef;
`endif
                    end else if (state_q == LOAD) begin
                        wr_en = 1'b1;
`ifdef IR_LOADER_CHECKSUM_EN
                        sum_d = sum_q + i_coef;
`endif
                        if (count_q == LAST) begin
                            count_d = '0;
`ifdef IR_LOADER_CHECKSUM_EN
                            state_d = CHECK;
`else
                            state_d = WAIT_SWAP;
`endif
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
`ifdef IR_LOADER_CHECKSUM_EN
                    else if (i_coef == sum_q) begin
                        state_d = WAIT_SWAP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
`endif
                end
            end
            WAIT_SWAP: begin
                if (i_swap_ok) begin
                    swap    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
`ifdef IR_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
`ifdef IR_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    ir_bank_regs #(
        .fxp_size    (fxp_size),
        .frac_size   (frac_size),
        .window_size (window_size),
        .idx_w       (IDX_W)
    ) u_banks (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_idx_i  (wr_idx),
        .wr_data_i (i_coef),
        .swap_i    (swap),
        .ir_o      (o_ir),
        .updated_o (o_ir_updated)
    );

endmodule

// File: tb/tb_ir_stream_loader.sv
// tb/tb_ir_stream_loader.sv - self-checking bench for ir_stream_loader (window 4, Q4.12).
// Exercises the trailing checksum beat when IR_LOADER_CHECKSUM_EN is defined.
module tb_ir_stream_loader;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [15:0]       i_coef = '0;
    logic              i_coef_valid = 1'b0;
    logic              i_coef_sof = 1'b0;
    logic              o_coef_ready;
    logic              i_swap_ok = 1'b0;
    logic [3:0][15:0]  o_ir;
    logic              o_ir_updated;
    logic              o_busy;
    logic              o_err;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    int err_base = 0;

    logic [3:0][15:0] exp_ir;
    logic [3:0][15:0] frame;
    logic [3:0][15:0] identity;

    ir_stream_loader #(
        .fxp_size    (16),
        .frac_size   (12),
        .window_size (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_coef       (i_coef),
        .i_coef_valid (i_coef_valid),
        .i_coef_sof   (i_coef_sof),
        .o_coef_ready (o_coef_ready),
        .i_swap_ok    (i_swap_ok),
        .o_ir         (o_ir),
        .o_ir_updated (o_ir_updated),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] c, input bit sof, input bit sw);
        i_coef       = c;
        i_coef_sof   = sof;
        i_coef_valid = 1'b1;
        i_swap_ok    = sw;
        tick();
        i_coef_valid = 1'b0;
        i_coef_sof   = 1'b0;
        i_swap_ok    = 1'b0;
    endtask

    // Complete frame: sof on tap 0, then taps 1..3, then the checksum beat when enabled.
    task automatic send_frame(input logic [3:0][15:0] c, input bit swap_on_last);
`ifdef IR_LOADER_CHECKSUM_EN
        logic [15:0] s;
        s = c[0] + c[1] + c[2] + c[3];
        for (int i = 0; i < 4; i++) beat(c[i], i == 0, 1'b0);
        beat(s, 1'b0, swap_on_last);
`else
        for (int i = 0; i < 3; i++) beat(c[i], i == 0, 1'b0);
        beat(c[3], 1'b0, swap_on_last);
`endif
    endtask

    task automatic do_swap(input string tag);
        i_swap_ok = 1'b1;
        tick();
        i_swap_ok = 1'b0;
        chk({tag, "_ir"}, o_ir, exp_ir);
        chk({tag, "_upd_pulse"}, {63'd0, o_ir_updated}, 64'd1);
        chk({tag, "_idle"}, {63'd0, o_busy}, 64'd0);
        tick();
        chk({tag, "_upd_clear"}, {63'd0, o_ir_updated}, 64'd0);
    endtask

    initial begin
        identity = '0;
        identity[0] = 16'h1000;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        exp_ir = identity;
        chk("reset_ir", o_ir, exp_ir);
        chk("reset_busy", {63'd0, o_busy}, 64'd0);
        chk("reset_ready", {63'd0, o_coef_ready}, 64'd1);
        chk("reset_upd", {63'd0, o_ir_updated}, 64'd0);
        chk("reset_err", {63'd0, o_err}, 64'd0);

        // Basic frame with a long hold before the swap
        frame = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
        send_frame(frame, 1'b0);
        chk("f1_ready_low", {63'd0, o_coef_ready}, 64'd0);
        chk("f1_busy", {63'd0, o_busy}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("f1_hold_ir", o_ir, exp_ir);
            chk("f1_hold_upd", {63'd0, o_ir_updated}, 64'd0);
        end
        exp_ir = frame;
        do_swap("f1_swap");
        chk("f1_ir_value", o_ir, 64'h0400_0300_0200_0100);
        chk("f1_no_err", 64'(err_cnt), 64'd0);

        // Beats without sof in IDLE are dropped
        for (int i = 0; i < 3; i++) beat(16'($urandom), 1'b0, 1'b0);
        tick();
        chk("drop_ir", o_ir, exp_ir);
        chk("drop_busy", {63'd0, o_busy}, 64'd0);
        chk("drop_err", 64'(err_cnt), 64'd0);

        // Restart inside LOAD
        err_base = err_cnt;
        beat(16'($urandom), 1'b1, 1'b0);
        beat(16'($urandom), 1'b0, 1'b0);
        frame = {16'h0DDD, 16'h0CCC, 16'h0BBB, 16'h0AAA};
        send_frame(frame, 1'b0);
        tick();
        chk("restart_err_once", 64'(err_cnt - err_base), 64'd1);
        chk("restart_hold_ir", o_ir, exp_ir);
        exp_ir = frame;
        do_swap("restart_swap");

        // Last beat and swap strobe together: no bypass
        frame = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        send_frame(frame, 1'b1);
        chk("nobypass_ir", o_ir, exp_ir);
        chk("nobypass_upd", {63'd0, o_ir_updated}, 64'd0);
        chk("nobypass_busy", {63'd0, o_busy}, 64'd1);
        tick();
        chk("nobypass_hold", o_ir, exp_ir);
        exp_ir = frame;
        do_swap("nobypass_swap");

        // Randomized frames with optional truncated preamble and random swap delay
        for (int n = 0; n < 12; n++) begin
            int pre;
            err_base = err_cnt;
            pre = $urandom_range(0, 3);
            for (int k = 0; k < pre; k++) beat(16'($urandom), k == 0, 1'b0);
            for (int i = 0; i < 4; i++) frame[i] = 16'($urandom);
            send_frame(frame, 1'b0);
            repeat ($urandom_range(0, 4)) begin
                tick();
                chk("rand_hold_ir", o_ir, exp_ir);
                chk("rand_wait_ready", {63'd0, o_coef_ready}, 64'd0);
            end
            exp_ir = frame;
            do_swap("rand_swap");
            chk("rand_err", 64'(err_cnt - err_base), (pre > 0) ? 64'd1 : 64'd0);
        end

        // Reset during LOAD restores identity
        beat(16'h1234, 1'b1, 1'b0);
        beat(16'h5678, 1'b0, 1'b0);
        chk("rst_mid_busy_before", {63'd0, o_busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ir = identity;
        chk("rst_mid_ir", o_ir, exp_ir);
        chk("rst_mid_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_mid_ready", {63'd0, o_coef_ready}, 64'd1);
        beat(16'h7777, 1'b0, 1'b0);
        chk("rst_mid_dropped", {63'd0, o_busy}, 64'd0);

`ifdef IR_LOADER_CHECKSUM_EN
        // Correct checksum swaps
        frame = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
        for (int i = 0; i < 4; i++) beat(frame[i], i == 0, 1'b0);
        chk("cks_check_ready", {63'd0, o_coef_ready}, 64'd1);
        beat(16'h0A00, 1'b0, 1'b0);
        chk("cks_ok_wait", {63'd0, o_coef_ready}, 64'd0);
        exp_ir = frame;
        do_swap("cks_ok_swap");

        // Wrong checksum rejects the frame
        err_base = err_cnt;
        for (int i = 0; i < 4; i++) beat(16'h0100 * 16'(i + 5), i == 0, 1'b0);
        for (int i = 0; i < 4; i++) beat(frame[i], i == 0, 1'b0);
        beat(16'h0A01, 1'b0, 1'b0);
        chk("cks_bad_idle", {63'd0, o_busy}, 64'd0);
        tick();
        chk("cks_bad_err", 64'(err_cnt - err_base), 64'd2);
        chk("cks_bad_ir", o_ir, exp_ir);
        i_swap_ok = 1'b1;
        tick();
        i_swap_ok = 1'b0;
        chk("cks_bad_noswap", {63'd0, o_ir_updated}, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
